// File: rtl/tmds_channel_sequencer.sv
// Sequences one TMDS channel's symbol stream (control tokens, HDMI preamble/guard, pixels)
// into the serializer FIFO. Timing counters advance only when a symbol is actually written.
module tmds_channel_sequencer #(
  parameter int CHANNEL   = 0,
  parameter int HDMI_MODE = 1,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       symbol_fifo_full_i,
  output logic       write_symbol_o,
  output logic [9:0] symbol_o,
  input  logic       pixel_valid_i,
  input  logic [9:0] pixel_symbol_i,
  output logic       pixel_ready_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_ACT_L     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_L    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_GUARD_L   = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_PRE_L     = HW'(H_TOTAL - 10);
  localparam logic [HW-1:0] H_SYNC_LO_L = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_HI_L = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACT_L     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_L    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_LO_L = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_HI_L = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [VW-1:0] v_next;
  logic          in_active, in_guard, in_preamble, next_line_active;
  logic          hsync, vsync;
  logic [1:0]    ctrl;
  logic [9:0]    token;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= H_ACT_L;
      v_q <= V_LAST_L;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Slot classification; preamble and guard sit at the tail of the line preceding an active line.
  always_comb begin
    v_next           = (v_q == V_LAST_L) ? '0 : v_q + 1'b1;
    next_line_active = (v_next < V_ACT_L);
    in_active        = (v_q < V_ACT_L) && (h_q < H_ACT_L);
    in_guard         = (HDMI_MODE != 0) && next_line_active && (h_q >= H_GUARD_L);
    in_preamble      = (HDMI_MODE != 0) && next_line_active &&
                       (h_q >= H_PRE_L) && (h_q < H_GUARD_L);
    hsync = ((h_q >= H_SYNC_LO_L) && (h_q < H_SYNC_HI_L)) ? HSYNC_POL : ~HSYNC_POL;
    vsync = ((v_q >= V_SYNC_LO_L) && (v_q < V_SYNC_HI_L)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_comb begin
    ctrl = 2'b00;
    if (CHANNEL == 0)      ctrl = {vsync, hsync};
    else if (CHANNEL == 1) ctrl = in_preamble ? 2'b01 : 2'b00;
    case (ctrl)
      2'b00:   token = 10'b1101010100;
      2'b01:   token = 10'b0010101011;
      2'b10:   token = 10'b0101010100;
      default: token = 10'b1010101011;
    endcase
  end

  always_comb begin
    write_symbol_o = rst_ni & ~symbol_fifo_full_i & (~in_active | pixel_valid_i);
    pixel_ready_o  = rst_ni & ~symbol_fifo_full_i & in_active;
    frame_start_o  = write_symbol_o & (h_q == '0) & (v_q == '0);
    if (in_active)     symbol_o = pixel_symbol_i;
    else if (in_guard) symbol_o = (CHANNEL == 1) ? GUARD_CH1 : GUARD_CH02;
    else               symbol_o = token;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (write_symbol_o) begin
      if (h_q == H_LAST_L) begin
        h_d = '0;
        v_d = v_next;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

endmodule
